// File: rtl/avmm_lvds_bridge_pkg.sv
// Shared header layout for the AVMM/LVDS bridge request and response streams.
package avmm_lvds_bridge_pkg;

    localparam int HDR_CNT_W  = 11;
    localparam int HDR_ADDR_W = 19;

    typedef enum logic {READ = 1'b0, WRITE = 1'b1} tr_e;
    typedef enum logic {NOBURST = 1'b0, BURST = 1'b1} burst_e;

    typedef struct packed {
        tr_e                   tr;
        burst_e                burst;
        logic [HDR_CNT_W-1:0]  burstcnt_byteena;
        logic [HDR_ADDR_W-1:0] address;
    } hdr_t;

endpackage

// File: rtl/avmm_master_ctrl.sv
// Avalon-MM master: pops a header (plus write data) from the request FIFO, runs
// one read or write transaction and streams the header and read data back.
//
// state      | meaning
// IDLE       | waiting for a header in the request FIFO
// HDR_POP    | read strobe for the header word
// HDR_LATCH  | header on req_q_i, captured and decoded
// WDATA_WAIT | waiting until the whole write payload sits in the FIFO
// WPOP       | read strobe for one write data word
// WBEAT      | latch data word, hold avm_write_o until accepted
// RCMD       | wait for response room, later hold avm_read_o until accepted
// RDATA      | forward read data beats to the response stream
// RESP_HDR   | header word on the response stream
module avmm_master_ctrl
    import avmm_lvds_bridge_pkg::*;
#(
    parameter int  MAX_BURST = 1024,
    localparam int BW        = $clog2(MAX_BURST) + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    output logic          req_rdreq_o,
    input  logic [31:0]   req_q_i,
    input  logic          req_rdempty_i,
    input  logic [BW-1:0] req_rdusedw_i,
    output logic [31:0]   avm_address_o,
    output logic          avm_read_o,
    output logic          avm_write_o,
    output logic [31:0]   avm_writedata_o,
    output logic [3:0]    avm_byteenable_o,
    output logic [BW-1:0] avm_burstcount_o,
    input  logic          avm_waitrequest_i,
    input  logic          avm_readdatavalid_i,
    input  logic [31:0]   avm_readdata_i,
    output logic [31:0]   resp_data_o,
    output logic          resp_valid_o,
    input  logic          resp_afull_i
);

    typedef enum logic [3:0] {
        IDLE, HDR_POP, HDR_LATCH, WDATA_WAIT, WPOP, WBEAT, RCMD, RDATA, RESP_HDR
    } state_e;

    state_e        state;
    hdr_t          hdr;
    hdr_t          q_hdr;
    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] q_cnt;
    logic          hdr_sent;

    assign q_hdr = hdr_t'(req_q_i);

    // Beat count of the incoming header, clamped to MAX_BURST
    always_comb begin
        q_cnt = BW'(1);
        if (q_hdr.burst == BURST) begin
            if (q_hdr.burstcnt_byteena > HDR_CNT_W'(MAX_BURST))
                q_cnt = BW'(MAX_BURST);
            else
                q_cnt = BW'(q_hdr.burstcnt_byteena);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state            <= IDLE;
            hdr              <= '0;
            beat_cnt         <= '0;
            hdr_sent         <= 1'b0;
            req_rdreq_o      <= 1'b0;
            avm_address_o    <= '0;
            avm_read_o       <= 1'b0;
            avm_write_o      <= 1'b0;
            avm_writedata_o  <= '0;
            avm_byteenable_o <= '0;
            avm_burstcount_o <= '0;
            resp_data_o      <= '0;
            resp_valid_o     <= 1'b0;
        end else begin
            req_rdreq_o  <= 1'b0;
            resp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!req_rdempty_i) begin
                        req_rdreq_o <= 1'b1;
                        state       <= HDR_POP;
                    end
                end
                HDR_POP: state <= HDR_LATCH;
                HDR_LATCH: begin
                    hdr              <= q_hdr;
                    beat_cnt         <= q_cnt;
                    hdr_sent         <= 1'b0;
                    avm_address_o    <= 32'({q_hdr.address, 2'b00});
                    avm_burstcount_o <= q_cnt;
                    avm_byteenable_o <= (q_hdr.tr == WRITE && q_hdr.burst == NOBURST) ?
                                        q_hdr.burstcnt_byteena[3:0] : 4'hF;
                    if (q_cnt == '0) begin
                        resp_data_o  <= req_q_i;
                        resp_valid_o <= 1'b1;
                        state        <= RESP_HDR;
                    end else if (q_hdr.tr == WRITE) begin
                        state <= WDATA_WAIT;
                    end else begin
                        state <= RCMD;
                    end
                end
                WDATA_WAIT: begin
                    if (req_rdusedw_i >= beat_cnt) begin
                        req_rdreq_o <= 1'b1;
                        state       <= WPOP;
                    end
                end
                WPOP: state <= WBEAT;
                WBEAT: begin
                    // First cycle captures the popped word; then hold until accepted
                    if (!avm_write_o) begin
                        avm_writedata_o <= req_q_i;
                        avm_write_o     <= 1'b1;
                    end else if (!avm_waitrequest_i) begin
                        avm_write_o <= 1'b0;
                        beat_cnt    <= beat_cnt - BW'(1);
                        if (beat_cnt == BW'(1)) begin
                            resp_data_o  <= hdr;
                            resp_valid_o <= 1'b1;
                            state        <= RESP_HDR;
                        end else begin
                            req_rdreq_o <= 1'b1;
                            state       <= WPOP;
                        end
                    end
                end
                RCMD: begin
                    if (!hdr_sent) begin
                        if (!resp_afull_i) begin
                            resp_data_o  <= hdr;
                            resp_valid_o <= 1'b1;
                            hdr_sent     <= 1'b1;
                            state        <= RESP_HDR;
                        end
                    end else if (!avm_waitrequest_i) begin
                        avm_read_o <= 1'b0;
                        state      <= RDATA;
                    end
                end
                RDATA: begin
                    if (avm_readdatavalid_i) begin
                        resp_data_o  <= avm_readdata_i;
                        resp_valid_o <= 1'b1;
                        beat_cnt     <= beat_cnt - BW'(1);
                        if (beat_cnt == BW'(1))
                            state <= IDLE;
                    end
                end
                RESP_HDR: begin
                    // Reads with a non-empty burst issue the command after the header
                    if (hdr.tr == READ && beat_cnt != '0) begin
                        avm_read_o <= 1'b1;
                        state      <= RCMD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avmm_master_ctrl.sv
// Directed bench for avmm_master_ctrl with request FIFO and Avalon slave models.
module tb_avmm_master_ctrl;

    localparam int MB = 16;
    localparam int BW = $clog2(MB) + 1;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        int          bc;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] addr;
        int          bc;
    } rd_t;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b1;
    logic          req_rdreq_o;
    logic [31:0]   req_q_i = '0;
    logic          req_rdempty_i = 1'b1;
    logic [BW-1:0] req_rdusedw_i = '0;
    logic [31:0]   avm_address_o;
    logic          avm_read_o;
    logic          avm_write_o;
    logic [31:0]   avm_writedata_o;
    logic [3:0]    avm_byteenable_o;
    logic [BW-1:0] avm_burstcount_o;
    logic          avm_waitrequest_i = 1'b0;
    logic          avm_readdatavalid_i = 1'b0;
    logic [31:0]   avm_readdata_i = '0;
    logic [31:0]   resp_data_o;
    logic          resp_valid_o;
    logic          resp_afull_i = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] fifo[$];
    logic [31:0] resp_exp[$];
    wr_t         wr_exp[$];
    rd_t         rd_exp[$];

    int          wait_cycles = 0;
    logic [31:0] rd_base = '0;
    int          rd_left = 0;
    int          rd_idx = 0;
    logic        rd_phase = 1'b0;
    int          hold_cnt = 0;

    int cmd_cycles = 0;
    int resp_cnt = 0;
    int wr_beats = 0;
    int rd_hold = 0;
    int last_rd_hold = 0;

    always #5 clk_i = ~clk_i;

    avmm_master_ctrl #(.MAX_BURST(MB)) dut (
        .clk_i               (clk_i),
        .rst_n_i             (rst_n_i),
        .req_rdreq_o         (req_rdreq_o),
        .req_q_i             (req_q_i),
        .req_rdempty_i       (req_rdempty_i),
        .req_rdusedw_i       (req_rdusedw_i),
        .avm_address_o       (avm_address_o),
        .avm_read_o          (avm_read_o),
        .avm_write_o         (avm_write_o),
        .avm_writedata_o     (avm_writedata_o),
        .avm_byteenable_o    (avm_byteenable_o),
        .avm_burstcount_o    (avm_burstcount_o),
        .avm_waitrequest_i   (avm_waitrequest_i),
        .avm_readdatavalid_i (avm_readdatavalid_i),
        .avm_readdata_i      (avm_readdata_i),
        .resp_data_o         (resp_data_o),
        .resp_valid_o        (resp_valid_o),
        .resp_afull_i        (resp_afull_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_true(input string tag, input logic cond);
        checks++;
        assert (cond === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=1", tag, cond);
        end
    endtask

    function automatic logic [31:0] mk_hdr(input logic wr, input logic bu,
                                           input logic [10:0] cnt, input logic [18:0] a);
        return {wr, bu, cnt, a};
    endfunction

    // Normal-mode request FIFO: q valid the cycle after the strobe
    always @(posedge clk_i) begin
        logic rd;
        rd = req_rdreq_o;
        #1;
        if (rd && fifo.size() > 0) req_q_i = fifo.pop_front();
        req_rdempty_i = (fifo.size() == 0);
        req_rdusedw_i = BW'(fifo.size());
    end

    // Avalon slave: wait_cycles of waitrequest per command, read data every other cycle
    always @(posedge clk_i) begin
        logic acc_rd;
        int   bc_s;
        acc_rd = avm_read_o && !avm_waitrequest_i;
        bc_s   = int'(avm_burstcount_o);
        #1;
        avm_readdatavalid_i = 1'b0;
        if (!rst_n_i) begin
            rd_left = 0;
            hold_cnt = 0;
            avm_waitrequest_i = 1'b0;
        end else begin
            if (rd_left > 0) begin
                if (rd_phase) begin
                    avm_readdatavalid_i = 1'b1;
                    avm_readdata_i = rd_base + 32'(rd_idx);
                    rd_idx++;
                    rd_left--;
                end
                rd_phase = !rd_phase;
            end
            if (acc_rd) begin
                rd_left = bc_s;
                rd_idx = 0;
                rd_phase = 1'b1;
            end
            if (avm_read_o || avm_write_o) begin
                avm_waitrequest_i = (hold_cnt < wait_cycles);
                hold_cnt = avm_waitrequest_i ? hold_cnt + 1 : 0;
            end else begin
                avm_waitrequest_i = 1'b0;
                hold_cnt = 0;
            end
        end
    end

    // Output monitor / scoreboard
    always @(negedge clk_i) begin
        wr_t e;
        rd_t r;
        if (!rst_n_i) begin
            rd_hold = 0;
        end else begin
            check_true("rw_exclusive", !(avm_read_o && avm_write_o));
            if (avm_read_o || avm_write_o) cmd_cycles++;
            if (resp_valid_o) begin
                resp_cnt++;
                check_true("resp_expected", resp_exp.size() != 0);
                if (resp_exp.size() != 0) check("resp_data", 64'(resp_data_o), 64'(resp_exp.pop_front()));
            end
            if (avm_write_o && !avm_waitrequest_i) begin
                wr_beats++;
                check_true("wr_expected", wr_exp.size() != 0);
                if (wr_exp.size() != 0) begin
                    e = wr_exp.pop_front();
                    check("wr_addr", 64'(avm_address_o), 64'(e.addr));
                    check("wr_be", 64'(avm_byteenable_o), 64'(e.be));
                    check("wr_bc", 64'(avm_burstcount_o), 64'(e.bc));
                    check("wr_data", 64'(avm_writedata_o), 64'(e.data));
                end
            end
            if (avm_read_o) begin
                rd_hold++;
                if (!avm_waitrequest_i) begin
                    last_rd_hold = rd_hold;
                    rd_hold = 0;
                    check_true("rd_expected", rd_exp.size() != 0);
                    if (rd_exp.size() != 0) begin
                        r = rd_exp.pop_front();
                        check("rd_addr", 64'(avm_address_o), 64'(r.addr));
                        check("rd_bc", 64'(avm_burstcount_o), 64'(r.bc));
                        check("rd_be", 64'(avm_byteenable_o), 64'h0F);
                    end
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_rdreq"}, 64'(req_rdreq_o), 64'd0);
        check({tag, "_read"}, 64'(avm_read_o), 64'd0);
        check({tag, "_write"}, 64'(avm_write_o), 64'd0);
        check({tag, "_addr"}, 64'(avm_address_o), 64'd0);
        check({tag, "_wdata"}, 64'(avm_writedata_o), 64'd0);
        check({tag, "_be"}, 64'(avm_byteenable_o), 64'd0);
        check({tag, "_bc"}, 64'(avm_burstcount_o), 64'd0);
        check({tag, "_rvalid"}, 64'(resp_valid_o), 64'd0);
        check({tag, "_rdata"}, 64'(resp_data_o), 64'd0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while ((resp_exp.size() != 0 || wr_exp.size() != 0 || rd_exp.size() != 0) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check_true({tag, "_done"}, resp_exp.size() == 0 && wr_exp.size() == 0 && rd_exp.size() == 0);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic exp_read(input logic bu, input logic [10:0] cnt, input logic [18:0] a, input int n);
        logic [31:0] h;
        h = mk_hdr(1'b0, bu, cnt, a);
        resp_exp.push_back(h);
        rd_exp.push_back('{addr: {11'b0, a, 2'b00}, bc: n});
        for (int i = 0; i < n; i++) resp_exp.push_back(rd_base + 32'(i));
        fifo.push_back(h);
    endtask

    task automatic exp_write_nb(input logic [3:0] be, input logic [18:0] a, input logic [31:0] d);
        logic [31:0] h;
        h = mk_hdr(1'b1, 1'b0, {7'b0, be}, a);
        resp_exp.push_back(h);
        wr_exp.push_back('{addr: {11'b0, a, 2'b00}, be: be, bc: 1, data: d});
        fifo.push_back(h);
        fifo.push_back(d);
    endtask

    initial begin
        int base;
        int c0;
        int r0;
        int n;
        logic [31:0] h;

        #1 rst_n_i = 1'b0;
        #1 check_reset("reset");
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // NOBURST write, byteenable 5
        wait_cycles = 1;
        base = wr_beats;
        exp_write_nb(4'h5, 19'h10, 32'hA1B2_C3D4);
        wait_done("nb_write", 200);
        check("nb_write_beats", 64'(wr_beats - base), 64'd1);

        // BURST write of 4, payload trickles in
        wait_cycles = 2;
        base = wr_beats;
        h = mk_hdr(1'b1, 1'b1, 11'd4, 19'h100);
        resp_exp.push_back(h);
        for (int i = 0; i < 4; i++)
            wr_exp.push_back('{addr: 32'h400, be: 4'hF, bc: 4, data: 32'h1111_0001 + 32'(i)});
        fifo.push_back(h);
        repeat (6) @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            fifo.push_back(32'h1111_0001 + 32'(i));
            repeat (4) @(negedge clk_i);
        end
        check("bw_no_early_write", 64'(wr_beats - base), 64'd0);
        fifo.push_back(32'h1111_0004);
        wait_done("burst_write", 300);
        check("bw_beats", 64'(wr_beats - base), 64'd4);

        // BURST read of 8, waitrequest 3 cycles
        wait_cycles = 3;
        rd_base = 32'hC0DE_0000;
        exp_read(1'b1, 11'd8, 19'h20, 8);
        wait_done("burst_read", 300);
        check("br_read_hold", 64'(last_rd_hold), 64'd4);

        // Read held back by afull
        wait_cycles = 0;
        rd_base = 32'h5A5A_0000;
        resp_afull_i = 1'b1;
        c0 = cmd_cycles;
        r0 = resp_cnt;
        exp_read(1'b0, 11'h7FF, 19'h33, 1);
        repeat (10) @(negedge clk_i);
        check("afull_no_cmd", 64'(cmd_cycles - c0), 64'd0);
        check("afull_no_resp", 64'(resp_cnt - r0), 64'd0);
        resp_afull_i = 1'b0;
        wait_done("afull_read", 200);
        check("afull_read_hold", 64'(last_rd_hold), 64'd1);

        // Zero-length bursts: header only, no command, no data popped
        c0 = cmd_cycles;
        h = mk_hdr(1'b1, 1'b1, 11'd0, 19'h55);
        resp_exp.push_back(h);
        fifo.push_back(h);
        h = mk_hdr(1'b0, 1'b1, 11'd0, 19'h66);
        resp_exp.push_back(h);
        fifo.push_back(h);
        wait_done("zero_burst", 200);
        check("zero_no_cmd", 64'(cmd_cycles - c0), 64'd0);
        check("zero_fifo_left", 64'(fifo.size()), 64'd0);

        // Burst length beyond MAX_BURST is clamped
        wait_cycles = 1;
        rd_base = 32'h7700_0000;
        exp_read(1'b1, 11'd20, 19'h5, MB);
        wait_done("clamp_read", 400);

        // NOBURST write with byteenable 0 still issues the write
        base = wr_beats;
        exp_write_nb(4'h0, 19'h7, 32'h1234_5678);
        wait_done("be0_write", 200);
        check("be0_beats", 64'(wr_beats - base), 64'd1);

        // Reset during beat 2 of a 4-beat write
        wait_cycles = 2;
        base = wr_beats;
        h = mk_hdr(1'b1, 1'b1, 11'd4, 19'h200);
        resp_exp.push_back(h);
        fifo.push_back(h);
        for (int i = 0; i < 4; i++) begin
            wr_exp.push_back('{addr: 32'h800, be: 4'hF, bc: 4, data: 32'hBEE0_0000 + 32'(i)});
            fifo.push_back(32'hBEE0_0000 + 32'(i));
        end
        n = 0;
        while (wr_beats < base + 1 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check_true("rst_beat1_seen", wr_beats >= base + 1);
        n = 0;
        while (!avm_write_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check_true("rst_beat2_seen", avm_write_o);
        rst_n_i = 1'b0;
        #1 check_reset("midreset");
        resp_exp.delete();
        wr_exp.delete();
        fifo.delete();
        r0 = resp_cnt;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (6) @(negedge clk_i);
        check("rst_no_resp", 64'(resp_cnt - r0), 64'd0);
        wait_cycles = 0;
        rd_base = 32'h4400_0000;
        exp_read(1'b0, 11'd0, 19'h44, 1);
        wait_done("post_reset_read", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
